// File: rtl/uart_ext.sv
// uart_ext: full-duplex UART with parameterised frame format.
// TX and RX are independent state machines sharing only clock and reset.
// The transmitter takes a frame through the level txreq and reports
// completion with a one-cycle txack. The receiver presents data with
// rxreq and keeps it there until the consumer returns rxack.
module uart_ext #(
  parameter int unsigned SYSHZ    = 100_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned DATABITS = 8,
  parameter int unsigned PARITY   = 0,
  parameter int unsigned STOPBITS = 1
) (
  input  logic                clk,
  input  logic                rst,
  output logic                tx,
  input  logic                rx,
  input  logic                txreq,
  output logic                txack,
  input  logic [DATABITS-1:0] txdata,
  output logic                rxreq,
  input  logic                rxack,
  output logic [DATABITS-1:0] rxdata,
  output logic                rxperr,
  output logic                rxferr,
  output logic                rxovr
);

  localparam int unsigned Int      = SYSHZ / BAUD;
  localparam int unsigned TW       = $clog2(Int) + 1;
  localparam int unsigned CW       = 4;
  localparam logic [TW-1:0] TLast  = TW'(Int - 1);
  localparam logic [TW-1:0] THalf  = TW'(Int / 2 - 1);
  localparam logic [CW-1:0] LastBit  = CW'(DATABITS - 1);
  localparam logic [CW-1:0] LastStop = CW'(STOPBITS - 1);
  localparam bit HasPar = (PARITY != 0);
  localparam bit OddPar = (PARITY == 1);

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxPar, TxStop, TxAck} tx_state_e;

  tx_state_e           tx_state_q, tx_state_d;
  logic [TW-1:0]       tx_tmr_q, tx_tmr_d;
  logic [CW-1:0]       tx_cnt_q, tx_cnt_d;
  logic [DATABITS-1:0] tx_sh_q, tx_sh_d;
  logic                tx_par_q, tx_par_d;
  logic                tx_q, tx_d;
  logic                tx_bit_end;

  // Next-state for the TX frame sequencer; tx_d is derived from the next state
  // so the line pin comes straight from a flop.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tmr_d   = tx_tmr_q;
    tx_cnt_d   = tx_cnt_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    tx_d       = 1'b1;
    tx_bit_end = (tx_tmr_q == '0);

    if (tx_state_q != TxIdle && tx_state_q != TxAck && !tx_bit_end) begin
      tx_tmr_d = tx_tmr_q - 1'b1;
    end

    unique case (tx_state_q)
      TxIdle: begin
        if (txreq) begin
          tx_state_d = TxStart;
          tx_tmr_d   = TLast;
          tx_sh_d    = txdata;
          tx_par_d   = (^txdata) ^ OddPar;
        end
      end
      TxStart: begin
        if (tx_bit_end) begin
          tx_state_d = TxData;
          tx_tmr_d   = TLast;
          tx_cnt_d   = '0;
        end
      end
      TxData: begin
        if (tx_bit_end) begin
          tx_tmr_d = TLast;
          if (tx_cnt_q == LastBit) begin
            tx_cnt_d   = '0;
            tx_state_d = HasPar ? TxPar : TxStop;
          end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
            tx_sh_d  = tx_sh_q >> 1;
          end
        end
      end
      TxPar: begin
        if (tx_bit_end) begin
          tx_state_d = TxStop;
          tx_tmr_d   = TLast;
          tx_cnt_d   = '0;
        end
      end
      TxStop: begin
        if (tx_bit_end) begin
          if (tx_cnt_q == LastStop) begin
            tx_state_d = TxAck;
          end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
            tx_tmr_d = TLast;
          end
        end
      end
      // txreq deliberately ignored here so a held request cannot restart early
      TxAck:   tx_state_d = TxIdle;
      default: tx_state_d = TxIdle;
    endcase

    unique case (tx_state_d)
      TxStart: tx_d = 1'b0;
      TxData:  tx_d = tx_sh_d[0];
      TxPar:   tx_d = tx_par_d;
      default: tx_d = 1'b1;
    endcase
  end

  // TX state register; reset forces the line idle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TxIdle;
      tx_tmr_q   <= '0;
      tx_cnt_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tmr_q   <= tx_tmr_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
    end
  end

  assign tx    = tx_q;
  assign txack = (tx_state_q == TxAck);

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rs_q, rs_prev_q;

  // Two-stage synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rs_q      <= 1'b1;
      rs_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rs_q      <= rx_meta_q;
      rs_prev_q <= rs_q;
    end
  end

  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxPar, RxStop, RxWait} rx_state_e;

  rx_state_e           rx_state_q, rx_state_d;
  logic [TW-1:0]       rx_tmr_q, rx_tmr_d;
  logic [CW-1:0]       rx_cnt_q, rx_cnt_d;
  logic [DATABITS-1:0] rx_sh_q, rx_sh_d;
  logic                rx_pbit_q, rx_pbit_d;
  logic                rx_tick;
  logic                frame_done;
  logic                frame_perr;

  // Next-state for the RX sequencer; all samples are taken at mid-bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tmr_d   = rx_tmr_q;
    rx_cnt_d   = rx_cnt_q;
    rx_sh_d    = rx_sh_q;
    rx_pbit_d  = rx_pbit_q;
    frame_done = 1'b0;
    rx_tick    = (rx_tmr_q == '0);

    if (rx_state_q != RxIdle && rx_state_q != RxWait && !rx_tick) begin
      rx_tmr_d = rx_tmr_q - 1'b1;
    end

    unique case (rx_state_q)
      RxIdle: begin
        if (rs_prev_q && !rs_q) begin
          rx_state_d = RxStart;
          rx_tmr_d   = THalf;
        end
      end
      RxStart: begin
        if (rx_tick) begin
          if (rs_q) begin
            // Line back high at mid start bit: treat as a glitch
            rx_state_d = RxIdle;
          end else begin
            rx_state_d = RxData;
            rx_tmr_d   = TLast;
            rx_cnt_d   = '0;
          end
        end
      end
      RxData: begin
        if (rx_tick) begin
          rx_sh_d  = {rs_q, rx_sh_q[DATABITS-1:1]};
          rx_tmr_d = TLast;
          if (rx_cnt_q == LastBit) begin
            rx_state_d = HasPar ? RxPar : RxStop;
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
      end
      RxPar: begin
        if (rx_tick) begin
          rx_pbit_d  = rs_q;
          rx_state_d = RxStop;
          rx_tmr_d   = TLast;
        end
      end
      RxStop: begin
        if (rx_tick) begin
          frame_done = 1'b1;
          // A low stop bit may be a break; re-arm only once the line is high
          rx_state_d = rs_q ? RxIdle : RxWait;
        end
      end
      RxWait: begin
        if (rs_q) rx_state_d = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  assign frame_perr = HasPar ? (rx_pbit_q ^ (^rx_sh_q) ^ OddPar) : 1'b0;

  // RX state register; reset discards any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= RxIdle;
      rx_tmr_q   <= '0;
      rx_cnt_q   <= '0;
      rx_sh_q    <= '0;
      rx_pbit_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_tmr_q   <= rx_tmr_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_sh_q    <= rx_sh_d;
      rx_pbit_q  <= rx_pbit_d;
    end
  end

  logic                rxreq_q, rxreq_d;
  logic [DATABITS-1:0] rxdata_q, rxdata_d;
  logic                rxperr_q, rxperr_d;
  logic                rxferr_q, rxferr_d;
  logic                rxovr_q, rxovr_d;

  // Output handshake: a frame arriving while the consumer still holds the
  // previous one is dropped, unless the consumer acks in that same cycle.
  always_comb begin
    rxreq_d  = rxreq_q;
    rxdata_d = rxdata_q;
    rxperr_d = rxperr_q;
    rxferr_d = rxferr_q;
    rxovr_d  = rxovr_q;

    if (rxreq_q && rxack) begin
      rxreq_d = 1'b0;
      rxovr_d = 1'b0;
    end

    if (frame_done) begin
      if (!rxreq_q || rxack) begin
        rxreq_d  = 1'b1;
        rxdata_d = rx_sh_q;
        rxperr_d = frame_perr;
        rxferr_d = !rs_q;
        rxovr_d  = 1'b0;
      end else begin
        rxovr_d = 1'b1;
      end
    end
  end

  // Output register for the consumer-facing RX interface.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxreq_q  <= 1'b0;
      rxdata_q <= '0;
      rxperr_q <= 1'b0;
      rxferr_q <= 1'b0;
      rxovr_q  <= 1'b0;
    end else begin
      rxreq_q  <= rxreq_d;
      rxdata_q <= rxdata_d;
      rxperr_q <= rxperr_d;
      rxferr_q <= rxferr_d;
      rxovr_q  <= rxovr_d;
    end
  end

  assign rxreq  = rxreq_q;
  assign rxdata = rxdata_q;
  assign rxperr = rxperr_q;
  assign rxferr = rxferr_q;
  assign rxovr  = rxovr_q;

endmodule

// File: tb/tb_uart_ext.sv
// Bench for uart_ext: three instances with different frame formats.
// u0: even parity, 2 stop bits (TX checks, loopback, reset)
// u1: no parity, 1 stop bit (framing error, overrun)
// u2: odd parity, 1 stop bit (glitch, parity error)
module tb_uart_ext;

  localparam int unsigned SysHz = 1_000_000;
  localparam int unsigned Baud  = 100_000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       txreq    = 1'b0;
  logic [7:0] txdata   = 8'h00;
  logic       line     = 1'b1;
  logic       loop     = 1'b0;
  logic [1:0] sel      = 2'd0;
  logic       mon_ack  = 1'b0;
  logic       man_ack  = 1'b0;
  logic       auto_ack = 1'b1;
  logic       done     = 1'b0;

  logic [2:0] tx_w, txack_w, rxreq_w, rxperr_w, rxferr_w, rxovr_w, rx_w, rxack_w;
  logic [7:0] rxdata_w [3];

  assign rx_w[0] = loop ? tx_w[0] : ((sel == 2'd0) ? line : 1'b1);
  assign rx_w[1] = (sel == 2'd1) ? line : 1'b1;
  assign rx_w[2] = (sel == 2'd2) ? line : 1'b1;
  assign rxack_w[0] = (sel == 2'd0) && (mon_ack || man_ack);
  assign rxack_w[1] = (sel == 2'd1) && (mon_ack || man_ack);
  assign rxack_w[2] = (sel == 2'd2) && (mon_ack || man_ack);

  uart_ext #(.SYSHZ(SysHz), .BAUD(Baud), .DATABITS(8), .PARITY(2), .STOPBITS(2)) u0 (
    .clk(clk), .rst(rst), .tx(tx_w[0]), .rx(rx_w[0]), .txreq(txreq), .txack(txack_w[0]),
    .txdata(txdata), .rxreq(rxreq_w[0]), .rxack(rxack_w[0]), .rxdata(rxdata_w[0]),
    .rxperr(rxperr_w[0]), .rxferr(rxferr_w[0]), .rxovr(rxovr_w[0])
  );
  uart_ext #(.SYSHZ(SysHz), .BAUD(Baud), .DATABITS(8), .PARITY(0), .STOPBITS(1)) u1 (
    .clk(clk), .rst(rst), .tx(tx_w[1]), .rx(rx_w[1]), .txreq(1'b0), .txack(txack_w[1]),
    .txdata(8'h00), .rxreq(rxreq_w[1]), .rxack(rxack_w[1]), .rxdata(rxdata_w[1]),
    .rxperr(rxperr_w[1]), .rxferr(rxferr_w[1]), .rxovr(rxovr_w[1])
  );
  uart_ext #(.SYSHZ(SysHz), .BAUD(Baud), .DATABITS(8), .PARITY(1), .STOPBITS(1)) u2 (
    .clk(clk), .rst(rst), .tx(tx_w[2]), .rx(rx_w[2]), .txreq(1'b0), .txack(txack_w[2]),
    .txdata(8'h00), .rxreq(rxreq_w[2]), .rxack(rxack_w[2]), .rxdata(rxdata_w[2]),
    .rxperr(rxperr_w[2]), .rxferr(rxferr_w[2]), .rxovr(rxovr_w[2])
  );

  typedef struct {
    logic [7:0] d;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } rx_exp_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  rx_exp_t sb[$];
  chk_t    cq[$];
  int      checks = 0;
  int      errors = 0;
  int      rises  = 0;

  // Monitor: the only process that counts; drains direct checks and compares
  // each received frame against the scoreboard.
  initial begin : monitor
    rx_exp_t e;
    chk_t    c;
    logic    req_prev;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      while (cq.size() != 0) begin
        c = cq.pop_front();
        checks++;
        if (c.act !== c.exp) begin
          errors++;
          $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, c.act, c.exp);
        end
      end
      mon_ack = 1'b0;
      if (rxreq_w[sel] && !req_prev) begin
        rises++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected: got rxdata 0x%0h on unit %0d, none expected",
                   rxdata_w[sel], sel);
        end else begin
          e = sb.pop_front();
          if ({rxdata_w[sel], rxperr_w[sel], rxferr_w[sel], rxovr_w[sel]} !==
              {e.d, e.perr, e.ferr, e.ovr}) begin
            errors++;
            $display("FAIL rx_frame: got data 0x%0h perr %b ferr %b ovr %b, expected data 0x%0h perr %b ferr %b ovr %b",
                     rxdata_w[sel], rxperr_w[sel], rxferr_w[sel], rxovr_w[sel],
                     e.d, e.perr, e.ferr, e.ovr);
          end
        end
        if (auto_ack) mon_ack = 1'b1;
      end
      req_prev = rxreq_w[sel];
      if (done && cq.size() == 0) begin
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    cq.push_back(c);
  endtask

  task automatic push_rx(input logic [7:0] d, input logic perr, input logic ferr, input logic ovr);
    rx_exp_t e;
    e.d    = d;
    e.perr = perr;
    e.ferr = ferr;
    e.ovr  = ovr;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Holding txreq two cycles is safe from both Idle and the ack cycle.
  task automatic send_tx(input logic [7:0] d);
    txdata = d;
    txreq  = 1'b1;
    tick(2);
    txreq  = 1'b0;
  endtask

  task automatic wait_txack(input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (txack_w[0]) found = 1'b1;
    end
    expect_eq("txack_seen", found, 1);
  endtask

  task automatic wait_sb(input int budget);
    for (int i = 0; i < budget && (sb.size() != 0 || rxreq_w[sel]); i++) tick(1);
    expect_eq("sb_drained", sb.size(), 0);
  endtask

  // Serial frame onto 'line'; leaves the line at the stop-bit level.
  task automatic drive_frame(input logic [7:0] d, input int pmode, input logic flip,
                             input logic stop_low);
    line = 1'b0;
    tick(10);
    for (int i = 0; i < 8; i++) begin
      line = d[i];
      tick(10);
    end
    if (pmode != 0) begin
      line = ((pmode == 1) ? ~^d : ^d) ^ flip;
      tick(10);
    end
    line = ~stop_low;
    tick(10);
  endtask

  initial begin : stim
    // start, A5 LSB first, even parity 0, two stop bits; bit 0 goes out first
    logic [11:0] pat;
    int          r0;
    pat = 12'b11_0_10100101_0;

    // Reset state
    tick(2);
    expect_eq("rst_tx", tx_w, 3'b111);
    expect_eq("rst_txack", txack_w, 3'b000);
    expect_eq("rst_rxreq", rxreq_w, 3'b000);
    expect_eq("rst_rxdata", rxdata_w[0], 8'h00);
    expect_eq("rst_flags", {rxperr_w, rxferr_w, rxovr_w}, 9'h000);
    rst = 1'b0;
    tick(3);

    // 1: TX 0xA5, even parity, 2 stops: 12 bits x 10 cycles then a txack pulse
    sel = 2'd0;
    txdata = 8'hA5;
    txreq  = 1'b1;
    tick(1);
    for (int k = 0; k < 120; k++) begin
      expect_eq("t1_tx_bit", tx_w[0], pat[k / 10]);
      expect_eq("t1_no_early_ack", txack_w[0], 0);
      if (k == 0) txreq = 1'b0;
      txdata = 8'h00;
      tick(1);
    end
    expect_eq("t1_txack_pulse", txack_w[0], 1);
    expect_eq("t1_tx_idle_at_ack", tx_w[0], 1);
    tick(1);
    expect_eq("t1_txack_single", txack_w[0], 0);
    tick(5);

    // 2: loopback, back-to-back frames
    loop = 1'b1;
    auto_ack = 1'b1;
    push_rx(8'h00, 1'b0, 1'b0, 1'b0);
    send_tx(8'h00);
    wait_txack(200);
    push_rx(8'hFF, 1'b0, 1'b0, 1'b0);
    send_tx(8'hFF);
    wait_txack(200);
    push_rx(8'h3C, 1'b0, 1'b0, 1'b0);
    send_tx(8'h3C);
    wait_txack(200);
    wait_sb(100);
    loop = 1'b0;
    tick(5);

    // 3: framing error on u1, then a long break must not retrigger
    sel = 2'd1;
    tick(2);
    r0 = rises;
    push_rx(8'h55, 1'b0, 1'b1, 1'b0);
    drive_frame(8'h55, 0, 1'b0, 1'b1);
    tick(50);
    line = 1'b1;
    tick(40);
    expect_eq("t3_one_rxreq", rises - r0, 1);
    wait_sb(20);

    // 4: overrun with rxack held low
    auto_ack = 1'b0;
    push_rx(8'h11, 1'b0, 1'b0, 1'b0);
    drive_frame(8'h11, 0, 1'b0, 1'b0);
    drive_frame(8'h22, 0, 1'b0, 1'b0);
    tick(10);
    expect_eq("t4_rxreq_held", rxreq_w[1], 1);
    expect_eq("t4_rxdata_first", rxdata_w[1], 8'h11);
    expect_eq("t4_rxovr_set", rxovr_w[1], 1);
    man_ack = 1'b1;
    tick(1);
    man_ack = 1'b0;
    expect_eq("t4_rxreq_drop", rxreq_w[1], 0);
    expect_eq("t4_rxovr_clear", rxovr_w[1], 0);
    expect_eq("t4_rxdata_held", rxdata_w[1], 8'h11);
    expect_eq("t4_sb_empty", sb.size(), 0);
    auto_ack = 1'b1;
    tick(5);

    // 5: glitch on u2, then odd-parity frames with bad and good parity
    sel = 2'd2;
    tick(2);
    r0 = rises;
    line = 1'b0;
    tick(3);
    line = 1'b1;
    tick(30);
    expect_eq("t5_glitch_ignored", rises - r0, 0);
    push_rx(8'h5A, 1'b1, 1'b0, 1'b0);
    drive_frame(8'h5A, 1, 1'b1, 1'b0);
    push_rx(8'h07, 1'b0, 1'b0, 1'b0);
    drive_frame(8'h07, 1, 1'b0, 1'b0);
    wait_sb(40);

    // 6: reset mid-frame at TX data bit 4 while RX is mid-frame via loopback
    sel  = 2'd0;
    loop = 1'b1;
    tick(2);
    send_tx(8'h00);
    tick(52);
    expect_eq("t6_tx_low_before_rst", tx_w[0], 0);
    #2;
    rst = 1'b1;
    #1;
    expect_eq("t6_tx_async_high", tx_w[0], 1);
    expect_eq("t6_rxreq_low", rxreq_w[0], 0);
    tick(3);
    rst = 1'b0;
    tick(5);
    expect_eq("t6_tx_idle", tx_w[0], 1);
    push_rx(8'h81, 1'b0, 1'b0, 1'b0);
    send_tx(8'h81);
    wait_txack(200);
    wait_sb(40);
    tick(5);
    done = 1'b1;
  end

endmodule
